sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; successor to the fixed 4-bit tile FIFO.

---
 rtl/sync_fifo_param_if.sv | 53 +++++
 rtl/sync_fifo_param.sv | 123 ++++++++++++
 tb/tb_sync_fifo_param.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_param_if
// Bundle of the write/read/status signals of sync_fifo_param.
//
// Handshake semantics (the single statement of them):
//   write: the producer raises wr_en with din. The word is taken at the rising
//          edge where wr_en=1 and (full=0, or a read is accepted at that same
//          edge). A write offered while full with no read is dropped, and
//          overflow is set.
//   read:  the consumer raises rd_en. The read is taken at the rising edge
//          where rd_en=1 and empty=0. A read offered while empty is ignored,
//          and underflow is set.
//          Registered mode: the popped word appears on dout after that edge,
//          with dout_valid high for one cycle.
//          Fall-through mode: dout shows the head word whenever dout_valid=1,
//          and rd_en pops it.
//
// Modports
//   master : producer/consumer side (drives wr_en, din, rd_en, clr_err)
//   slave  : FIFO side (drives data out and all status)
// ---------------------------------------------------------------------------
interface sync_fifo_param_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic             clr_err;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, din, rd_en, clr_err,
    input  dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, clr_err,
    output dout, dout_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Single-clock FIFO used as a rate-decoupling buffer. It has generic width and
// depth (the depth need not be a power of two), an occupancy count,
// programmable almost-full/almost-empty thresholds, sticky overflow/underflow
// flags, and a choice of registered or first-word-fall-through read.
//
// Ports
//   clk   : clock; all state changes on the rising edge
//   rst_n : synchronous reset, ACTIVE-HIGH despite its name (1 = reset)
//   bus   : sync_fifo_param_if.slave; the handshake is described in that file
//
// Parameters
//   WIDTH, DEPTH       : word width and number of entries. These must match
//                        the parameters of the connected interface.
//   AF_LEVEL/AE_LEVEL  : almost_full when count >= AF_LEVEL,
//                        almost_empty when count <= AE_LEVEL
//   FWFT               : 0 = registered read, 1 = head word shown on dout
// ---------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  sync_fifo_param_if.slave    bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             underflow_q;

  logic full_w;
  logic empty_w;
  logic rd_acc;
  logic wr_acc;
  logic wr_drop;
  logic rd_rej;

  // Explicit wrap, so that DEPTH does not have to be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // A read frees a slot at the same edge, so a full FIFO still accepts a
  // write that is paired with an accepted read.
  assign rd_acc  = bus.rd_en && !empty_w;
  assign wr_acc  = bus.wr_en && (!full_w || rd_acc);
  assign wr_drop = bus.wr_en && !wr_acc;
  assign rd_rej  = bus.rd_en && empty_w;

  // Storage is not reset. Writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst_n && wr_acc) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= next_ptr(wr_ptr);
      if (rd_acc) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // A fresh error in the same cycle as clr_err keeps its flag set.
      overflow_q  <= (overflow_q  && !bus.clr_err) || wr_drop;
      underflow_q <= (underflow_q && !bus.clr_err) || rd_rej;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // The head entry is always on dout. It is meaningful only while the
      // FIFO is not empty.
      assign bus.dout       = mem[rd_ptr];
      assign bus.dout_valid = !empty_w;
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;
      logic             dout_valid_q;

      always_ff @(posedge clk) begin
        if (rst_n) begin
          dout_q       <= '0;
          dout_valid_q <= 1'b0;
        end else begin
          if (rd_acc) dout_q <= mem[rd_ptr];
          dout_valid_q <= rd_acc;
        end
      end

      assign bus.dout       = dout_q;
      assign bus.dout_valid = dout_valid_q;
    end
  endgenerate

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param
// Drives two FIFOs with the same inputs:
//   dut0 : WIDTH=4, DEPTH=4, AF=3, AE=1, registered read
//   dut1 : WIDTH=4, DEPTH=5, AF=4, AE=1, first-word-fall-through
// Each FIFO is compared every cycle against a queue-based model. Directed
// tables and hand-written sequences add fixed expected values.
// ---------------------------------------------------------------------------
module tb_sync_fifo_param;
  localparam int W   = 4;
  localparam int D0  = 4;
  localparam int AF0 = 3;
  localparam int AE0 = 1;
  localparam int D1  = 5;
  localparam int AF1 = 4;
  localparam int AE1 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         wr_en;
  logic         rd_en;
  logic         clr_err;
  logic [W-1:0] din;

  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D0)) bus0 ();
  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D1)) bus1 ();

  assign bus0.wr_en   = wr_en;
  assign bus0.din     = din;
  assign bus0.rd_en   = rd_en;
  assign bus0.clr_err = clr_err;
  assign bus1.wr_en   = wr_en;
  assign bus1.din     = din;
  assign bus1.rd_en   = rd_en;
  assign bus1.clr_err = clr_err;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D0), .AF_LEVEL(AF0), .AE_LEVEL(AE0), .FWFT(1'b0))
    dut0 (.clk(clk), .rst_n(rst), .bus(bus0));
  sync_fifo_param #(.WIDTH(W), .DEPTH(D1), .AF_LEVEL(AF1), .AE_LEVEL(AE1), .FWFT(1'b1))
    dut1 (.clk(clk), .rst_n(rst), .bus(bus1));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference models: one queue of stored words per FIFO.
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] m0_dout;
  logic         m0_dv;
  logic         m0_ovf, m0_unf, m1_ovf, m1_unf;

  task automatic model_step();
    bit ra, wa;
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      m0_dout = '0;
      m0_dv   = 1'b0;
      m0_ovf  = 1'b0;
      m0_unf  = 1'b0;
      m1_ovf  = 1'b0;
      m1_unf  = 1'b0;
    end else begin
      ra = rd_en && (exp_q0.size() != 0);
      wa = wr_en && ((exp_q0.size() < D0) || ra);
      m0_dv = ra;
      if (ra) m0_dout = exp_q0.pop_front();
      if (wa) exp_q0.push_back(din);
      m0_ovf = (m0_ovf && !clr_err) || (wr_en && !wa);
      m0_unf = (m0_unf && !clr_err) || (rd_en && !ra);

      ra = rd_en && (exp_q1.size() != 0);
      wa = wr_en && ((exp_q1.size() < D1) || ra);
      if (ra) void'(exp_q1.pop_front());
      if (wa) exp_q1.push_back(din);
      m1_ovf = (m1_ovf && !clr_err) || (wr_en && !wa);
      m1_unf = (m1_unf && !clr_err) || (rd_en && !ra);
    end
  endtask

  task automatic check_models(input string tag);
    int n0, n1;
    n0 = exp_q0.size();
    n1 = exp_q1.size();
    chk({tag, " d0.count"}, 32'(bus0.count), 32'(n0));
    chk({tag, " d0.dout"}, 32'(bus0.dout), 32'(m0_dout));
    chk({tag, " d0.dout_valid"}, 32'(bus0.dout_valid), 32'(m0_dv));
    chk({tag, " d0.full"}, 32'(bus0.full), 32'(n0 == D0));
    chk({tag, " d0.empty"}, 32'(bus0.empty), 32'(n0 == 0));
    chk({tag, " d0.almost_full"}, 32'(bus0.almost_full), 32'(n0 >= AF0));
    chk({tag, " d0.almost_empty"}, 32'(bus0.almost_empty), 32'(n0 <= AE0));
    chk({tag, " d0.overflow"}, 32'(bus0.overflow), 32'(m0_ovf));
    chk({tag, " d0.underflow"}, 32'(bus0.underflow), 32'(m0_unf));
    chk({tag, " d1.count"}, 32'(bus1.count), 32'(n1));
    chk({tag, " d1.dout_valid"}, 32'(bus1.dout_valid), 32'(n1 != 0));
    if (n1 != 0) chk({tag, " d1.dout"}, 32'(bus1.dout), 32'(exp_q1[0]));
    chk({tag, " d1.full"}, 32'(bus1.full), 32'(n1 == D1));
    chk({tag, " d1.empty"}, 32'(bus1.empty), 32'(n1 == 0));
    chk({tag, " d1.almost_full"}, 32'(bus1.almost_full), 32'(n1 >= AF1));
    chk({tag, " d1.almost_empty"}, 32'(bus1.almost_empty), 32'(n1 <= AE1));
    chk({tag, " d1.overflow"}, 32'(bus1.overflow), 32'(m1_ovf));
    chk({tag, " d1.underflow"}, 32'(bus1.underflow), 32'(m1_unf));
  endtask

  // ---------------- driver ----------------
  // Inputs change 1 ns after an edge, and outputs are sampled 1 ns after the
  // next edge.
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic r,
                       input logic c, input string tag);
    wr_en   = w;
    din     = d;
    rd_en   = r;
    clr_err = c;
    @(posedge clk);
    model_step();
    #1;
    check_models(tag);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, "reset");
    rst = 1'b0;
  endtask

  // ---------------- directed vector table (dut0) ----------------
  typedef struct {
    logic         wr;
    logic [W-1:0] d;
    logic         rd;
    logic         clr;
    int           cnt;
    logic [W-1:0] dout;
    logic         dv;
    logic         full;
    logic         af;
    logic         ovf;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic wr, logic [W-1:0] d, logic rd, logic clr, int cnt,
                              logic [W-1:0] dout, logic dv, logic full, logic af, logic ovf);
    vec_t v;
    v.wr = wr; v.d = d; v.rd = rd; v.clr = clr; v.cnt = cnt;
    v.dout = dout; v.dv = dv; v.full = full; v.af = af; v.ovf = ovf;
    return v;
  endfunction

  initial begin
    logic [W-1:0] pass_exp [6];
    logic [W-1:0] drain_exp [4];
    int wp;
    logic rw, rr, rc;

    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;

    // 1: reset held for two cycles
    do_reset(2);
    chk("reset count", 32'(bus0.count), 32'd0);
    chk("reset empty", 32'(bus0.empty), 32'd1);
    chk("reset full", 32'(bus0.full), 32'd0);
    chk("reset dout", 32'(bus0.dout), 32'd0);
    chk("reset dout_valid", 32'(bus0.dout_valid), 32'd0);
    chk("reset flags", 32'({bus0.overflow, bus0.underflow, bus0.almost_full}), 32'd0);
    chk("reset almost_empty", 32'(bus0.almost_empty), 32'd1);

    // 2: ordering, then 3: full/overflow/clear
    vt.push_back(mk(1, 4'hA, 0, 0, 1, 4'h0, 0, 0, 0, 0));
    vt.push_back(mk(1, 4'hC, 0, 0, 2, 4'h0, 0, 0, 0, 0));
    vt.push_back(mk(1, 4'h3, 0, 0, 3, 4'h0, 0, 0, 1, 0));
    vt.push_back(mk(0, 4'h0, 1, 0, 2, 4'hA, 1, 0, 0, 0));
    vt.push_back(mk(0, 4'h0, 1, 0, 1, 4'hC, 1, 0, 0, 0));
    vt.push_back(mk(0, 4'h0, 1, 0, 0, 4'h3, 1, 0, 0, 0));
    vt.push_back(mk(0, 4'h0, 0, 0, 0, 4'h3, 0, 0, 0, 0));
    vt.push_back(mk(1, 4'h1, 0, 0, 1, 4'h3, 0, 0, 0, 0));
    vt.push_back(mk(1, 4'h2, 0, 0, 2, 4'h3, 0, 0, 0, 0));
    vt.push_back(mk(1, 4'h3, 0, 0, 3, 4'h3, 0, 0, 1, 0));
    vt.push_back(mk(1, 4'h4, 0, 0, 4, 4'h3, 0, 1, 1, 0));
    vt.push_back(mk(1, 4'h5, 0, 0, 4, 4'h3, 0, 1, 1, 1));
    vt.push_back(mk(0, 4'h0, 1, 0, 3, 4'h1, 1, 0, 1, 1));
    vt.push_back(mk(0, 4'h0, 1, 0, 2, 4'h2, 1, 0, 0, 1));
    vt.push_back(mk(0, 4'h0, 1, 0, 1, 4'h3, 1, 0, 0, 1));
    vt.push_back(mk(0, 4'h0, 1, 0, 0, 4'h4, 1, 0, 0, 1));
    vt.push_back(mk(0, 4'h0, 0, 1, 0, 4'h4, 0, 0, 0, 0));

    foreach (vt[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      cycle(vt[i].wr, vt[i].d, vt[i].rd, vt[i].clr, t);
      chk({t, " count"}, 32'(bus0.count), 32'(vt[i].cnt));
      chk({t, " dout"}, 32'(bus0.dout), 32'(vt[i].dout));
      chk({t, " dout_valid"}, 32'(bus0.dout_valid), 32'(vt[i].dv));
      chk({t, " full"}, 32'(bus0.full), 32'(vt[i].full));
      chk({t, " almost_full"}, 32'(bus0.almost_full), 32'(vt[i].af));
      chk({t, " overflow"}, 32'(bus0.overflow), 32'(vt[i].ovf));
    end

    // 4: wrap with simultaneous read+write while full
    do_reset(1);
    for (int i = 1; i <= 4; i++) cycle(1'b1, W'(i), 1'b0, 1'b0, "fill");
    chk("fill full", 32'(bus0.full), 32'd1);
    pass_exp = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7};
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, W'(6 + i), 1'b1, 1'b0, "rdwr");
      chk($sformatf("rdwr%0d count", i), 32'(bus0.count), 32'd4);
      chk($sformatf("rdwr%0d overflow", i), 32'(bus0.overflow), 32'd0);
      chk($sformatf("rdwr%0d dout", i), 32'(bus0.dout), 32'(pass_exp[i]));
    end
    drain_exp = '{4'h8, 4'h9, 4'hA, 4'hB};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, "drain");
      chk($sformatf("drain%0d dout", i), 32'(bus0.dout), 32'(drain_exp[i]));
    end
    chk("drain empty", 32'(bus0.empty), 32'd1);

    // 5: empty corners
    do_reset(1);
    cycle(1'b0, '0, 1'b1, 1'b0, "rd_empty");
    chk("rd_empty underflow", 32'(bus0.underflow), 32'd1);
    chk("rd_empty count", 32'(bus0.count), 32'd0);
    cycle(1'b1, 4'h7, 1'b1, 1'b0, "rdwr_empty");
    chk("rdwr_empty count", 32'(bus0.count), 32'd1);
    chk("rdwr_empty dout_valid", 32'(bus0.dout_valid), 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b0, "rd_after");
    chk("rd_after dout", 32'(bus0.dout), 32'h7);
    chk("rd_after dout_valid", 32'(bus0.dout_valid), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b1, "clr_vs_new");
    chk("clr_vs_new underflow", 32'(bus0.underflow), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b1, "clr");
    chk("clr underflow", 32'(bus0.underflow), 32'd0);

    // 6: fall-through FIFO (dut1)
    do_reset(1);
    cycle(1'b1, 4'h9, 1'b0, 1'b0, "fwft_wr");
    chk("fwft dout", 32'(bus1.dout), 32'h9);
    chk("fwft dout_valid", 32'(bus1.dout_valid), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b0, "fwft_rd");
    chk("fwft_rd empty", 32'(bus1.empty), 32'd1);
    chk("fwft_rd dout_valid", 32'(bus1.dout_valid), 32'd0);
    for (int i = 1; i <= 3; i++) cycle(1'b1, W'(i), 1'b0, 1'b0, "fwft_fill");
    chk("fwft_fill count", 32'(bus1.count), 32'd3);
    chk("fwft_fill head", 32'(bus1.dout), 32'h1);
    rst = 1'b1;
    cycle(1'b1, 4'hF, 1'b1, 1'b0, "fwft_rst");
    rst = 1'b0;
    chk("fwft_rst empty", 32'(bus1.empty), 32'd1);
    chk("fwft_rst count", 32'(bus1.count), 32'd0);

    // Randomised traffic. The write/read balance changes every 100 cycles so
    // that both FIFOs spend time near full and near empty.
    do_reset(1);
    for (int i = 0; i < 800; i++) begin
      wp = ((i / 100) % 2 == 0) ? 3 : 1;
      rw = ($urandom_range(0, 3) < wp);
      rr = ($urandom_range(0, 3) >= wp);
      rc = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle(rw, W'($urandom_range(0, 15)), rr, rc, $sformatf("rnd%0d", i));
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
